// File: rtl/axi_nx1_arbiter_pkg.sv
// Shared AXI3 encodings, field widths and FSM state types for the N:1 arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package axi_nx1_arbiter_pkg;

    // Per-field widths of the fixed-size AXI3 sideband fields
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int RESP_W  = 2;

    // Arbitration policy selectors
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } axi_size_e;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    // Width of an encoded master index; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_nx1_arbiter_if.sv
// AXI3 bundle carrying N packed slots (slot i at bits [i*W +: W], slot 0 at LSB).
// Latency: none (wiring only).
// Backpressure: per-slot valid/ready on every channel.
interface axi_nx1_arbiter_if
    import axi_nx1_arbiter_pkg::*;
#(
    parameter int N      = 1,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [N*ID_W-1:0]    arid;
    logic [N*ADDR_W-1:0]  araddr;
    logic [N*LEN_W-1:0]   arlen;
    logic [N*SIZE_W-1:0]  arsize;
    logic [N*BURST_W-1:0] arburst;
    logic [N*LOCK_W-1:0]  arlock;
    logic [N*CACHE_W-1:0] arcache;
    logic [N*PROT_W-1:0]  arprot;
    logic [N-1:0]         arvalid;
    logic [N-1:0]         arready;

    logic [N*ID_W-1:0]    rid;
    logic [N*DATA_W-1:0]  rdata;
    logic [N*RESP_W-1:0]  rresp;
    logic [N-1:0]         rlast;
    logic [N-1:0]         rvalid;
    logic [N-1:0]         rready;

    logic [N*ID_W-1:0]    awid;
    logic [N*ADDR_W-1:0]  awaddr;
    logic [N*LEN_W-1:0]   awlen;
    logic [N*SIZE_W-1:0]  awsize;
    logic [N*BURST_W-1:0] awburst;
    logic [N*LOCK_W-1:0]  awlock;
    logic [N*CACHE_W-1:0] awcache;
    logic [N*PROT_W-1:0]  awprot;
    logic [N-1:0]         awvalid;
    logic [N-1:0]         awready;

    logic [N*ID_W-1:0]    wid;
    logic [N*DATA_W-1:0]  wdata;
    logic [N*STRB_W-1:0]  wstrb;
    logic [N-1:0]         wlast;
    logic [N-1:0]         wvalid;
    logic [N-1:0]         wready;

    logic [N*ID_W-1:0]    bid;
    logic [N*RESP_W-1:0]  bresp;
    logic [N-1:0]         bvalid;
    logic [N-1:0]         bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_nx1_arbiter_arb.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed lowest-index-wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller samples gnt/idx only when it can accept a new owner.
module rr_arbiter
    import axi_nx1_arbiter_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = ARB_RR,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Walk the slots starting at ptr (or at 0 for fixed priority); first requester wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((MODE == ARB_FIXED) ? i : (int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/axi_nx1_arbiter.sv
// N-master to 1-slave AXI3 arbiter with independent read and write owners, one transaction each.
// Latency: s_*valid to m_*valid 1 cycle (arbitrate in IDLE, route from latched grant); data/resp pass through.
// Backpressure: ready from the slave port is steered to the owner only; non-owners see ready=0, W held off until AW accepted.
module axi_nx1_arbiter
    import axi_nx1_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = ARB_RR
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi_nx1_arbiter_if.slave       s_axi,
    axi_nx1_arbiter_if.master      m_axi,
    output logic [NUM_MASTERS-1:0] rd_gnt,
    output logic [NUM_MASTERS-1:0] wr_gnt
);

    localparam int N      = NUM_MASTERS;
    localparam int IDX_W  = idx_w(N);
    localparam int STRB_W = DATA_W / 8;

    // Pointer advance past the slot that just won, wrapping N-1 -> 0
    function automatic logic [IDX_W-1:0] next_slot(input logic [IDX_W-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    rd_state_e        rd_st;
    wr_state_e        wr_st;
    logic [IDX_W-1:0] rd_idx, wr_idx, rd_ptr, wr_ptr;
    logic [IDX_W-1:0] rd_arb_idx, wr_arb_idx;
    logic [N-1:0]     rd_arb_gnt, wr_arb_gnt;
    logic             ar_hs, r_done, aw_hs, w_done, b_done;

    rr_arbiter #(.N(N), .MODE(ARB_MODE)) u_rd_arb (
        .req (s_axi.arvalid),
        .ptr (rd_ptr),
        .gnt (rd_arb_gnt),
        .idx (rd_arb_idx)
    );

    rr_arbiter #(.N(N), .MODE(ARB_MODE)) u_wr_arb (
        .req (s_axi.awvalid),
        .ptr (wr_ptr),
        .gnt (wr_arb_gnt),
        .idx (wr_arb_idx)
    );

    assign ar_hs  = m_axi.arvalid & m_axi.arready;
    assign r_done = m_axi.rvalid & m_axi.rready & m_axi.rlast;
    assign aw_hs  = m_axi.awvalid & m_axi.awready;
    assign w_done = m_axi.wvalid & m_axi.wready & m_axi.wlast;
    assign b_done = m_axi.bvalid & m_axi.bready;

    // Read owner FSM; pointer moves on the address handshake so a dropped request keeps its turn
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_st  <= R_IDLE;
            rd_gnt <= '0;
            rd_idx <= '0;
            rd_ptr <= '0;
        end else begin
            case (rd_st)
                R_IDLE: if (|s_axi.arvalid) begin
                    rd_gnt <= rd_arb_gnt;
                    rd_idx <= rd_arb_idx;
                    rd_st  <= R_ADDR;
                end
                R_ADDR: if (ar_hs) begin
                    rd_st <= R_DATA;
                    if (ARB_MODE == ARB_RR) rd_ptr <= next_slot(rd_idx);
                end
                R_DATA: if (r_done) begin
                    rd_st  <= R_IDLE;
                    rd_gnt <= '0;
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

    // Write owner FSM; W and B stay bound to the AW winner until the response is taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_st  <= W_IDLE;
            wr_gnt <= '0;
            wr_idx <= '0;
            wr_ptr <= '0;
        end else begin
            case (wr_st)
                W_IDLE: if (|s_axi.awvalid) begin
                    wr_gnt <= wr_arb_gnt;
                    wr_idx <= wr_arb_idx;
                    wr_st  <= W_ADDR;
                end
                W_ADDR: if (aw_hs) begin
                    wr_st <= W_DATA;
                    if (ARB_MODE == ARB_RR) wr_ptr <= next_slot(wr_idx);
                end
                W_DATA: if (w_done) wr_st <= W_RESP;
                W_RESP: if (b_done) begin
                    wr_st  <= W_IDLE;
                    wr_gnt <= '0;
                end
                default: wr_st <= W_IDLE;
            endcase
        end
    end

    // AR: slot mux on the latched index; valid tracks the owner's live request (no cancel)
    assign m_axi.arid    = s_axi.arid[rd_idx*ID_W +: ID_W];
    assign m_axi.araddr  = s_axi.araddr[rd_idx*ADDR_W +: ADDR_W];
    assign m_axi.arlen   = s_axi.arlen[rd_idx*LEN_W +: LEN_W];
    assign m_axi.arsize  = s_axi.arsize[rd_idx*SIZE_W +: SIZE_W];
    assign m_axi.arburst = s_axi.arburst[rd_idx*BURST_W +: BURST_W];
    assign m_axi.arlock  = s_axi.arlock[rd_idx*LOCK_W +: LOCK_W];
    assign m_axi.arcache = s_axi.arcache[rd_idx*CACHE_W +: CACHE_W];
    assign m_axi.arprot  = s_axi.arprot[rd_idx*PROT_W +: PROT_W];
    assign m_axi.arvalid = (rd_st == R_ADDR) & s_axi.arvalid[rd_idx];
    assign s_axi.arready = (rd_st == R_ADDR) ? (rd_gnt & {N{m_axi.arready}}) : '0;

    // R: payload broadcast, valid steered by the latched owner, never by rid
    assign s_axi.rid    = {N{m_axi.rid}};
    assign s_axi.rdata  = {N{m_axi.rdata}};
    assign s_axi.rresp  = {N{m_axi.rresp}};
    assign s_axi.rlast  = {N{m_axi.rlast}};
    assign s_axi.rvalid = (rd_st == R_DATA) ? (rd_gnt & {N{m_axi.rvalid}}) : '0;
    assign m_axi.rready = (rd_st == R_DATA) & s_axi.rready[rd_idx];

    // AW
    assign m_axi.awid    = s_axi.awid[wr_idx*ID_W +: ID_W];
    assign m_axi.awaddr  = s_axi.awaddr[wr_idx*ADDR_W +: ADDR_W];
    assign m_axi.awlen   = s_axi.awlen[wr_idx*LEN_W +: LEN_W];
    assign m_axi.awsize  = s_axi.awsize[wr_idx*SIZE_W +: SIZE_W];
    assign m_axi.awburst = s_axi.awburst[wr_idx*BURST_W +: BURST_W];
    assign m_axi.awlock  = s_axi.awlock[wr_idx*LOCK_W +: LOCK_W];
    assign m_axi.awcache = s_axi.awcache[wr_idx*CACHE_W +: CACHE_W];
    assign m_axi.awprot  = s_axi.awprot[wr_idx*PROT_W +: PROT_W];
    assign m_axi.awvalid = (wr_st == W_ADDR) & s_axi.awvalid[wr_idx];
    assign s_axi.awready = (wr_st == W_ADDR) ? (wr_gnt & {N{m_axi.awready}}) : '0;

    // W: only open once the owner's AW has been accepted
    assign m_axi.wid    = s_axi.wid[wr_idx*ID_W +: ID_W];
    assign m_axi.wdata  = s_axi.wdata[wr_idx*DATA_W +: DATA_W];
    assign m_axi.wstrb  = s_axi.wstrb[wr_idx*STRB_W +: STRB_W];
    assign m_axi.wlast  = s_axi.wlast[wr_idx];
    assign m_axi.wvalid = (wr_st == W_DATA) & s_axi.wvalid[wr_idx];
    assign s_axi.wready = (wr_st == W_DATA) ? (wr_gnt & {N{m_axi.wready}}) : '0;

    // B
    assign s_axi.bid    = {N{m_axi.bid}};
    assign s_axi.bresp  = {N{m_axi.bresp}};
    assign s_axi.bvalid = (wr_st == W_RESP) ? (wr_gnt & {N{m_axi.bvalid}}) : '0;
    assign m_axi.bready = (wr_st == W_RESP) & s_axi.bready[wr_idx];

endmodule
